// File: rtl/mem_access_unit.sv
// Load/store initiator for a byte-addressed, full-word RAM port; sub-word stores use read-modify-write.
// Optional access checking (range, alignment, reserved size) is enabled by defining MAU_ACCESS_CHECK_EN.
module mem_access_unit #(
    parameter int unsigned MEM_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_dataIn,
    output logic        mem_write,
    output logic        mem_word,
    output logic        mem_sign,
    input  logic [31:0] mem_dataOut
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        write_q;
    logic        err_q;
    logic [31:0] old_q;

    logic        accept;
    logic        sub_word;
    logic        access_bad;
    logic [31:0] merged_wdata;
    logic [31:0] load_data;

    assign accept   = req_valid && req_ready;
    assign sub_word = (req_size == SZ_BYTE) || (req_size == SZ_HALF);

`ifdef MAU_ACCESS_CHECK_EN
    // End address is formed in 33 bits so an access near 2^32 cannot wrap into range.
    logic [32:0] end_addr;
    assign end_addr   = {1'b0, req_addr} + 33'd3;
    assign access_bad = (end_addr > 33'(MEM_LIMIT))
                     || ((req_size == SZ_HALF) && req_addr[0])
                     || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                     || (req_size == SZ_RSVD);
`else
    logic unused_limit;
    assign unused_limit = (MEM_LIMIT == 0);
    assign access_bad   = 1'b0;
`endif

    // NOTE: every variable in a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (access_bad)
                        state_nxt = S_RESP;
                    else if (!req_write || sub_word)
                        state_nxt = S_RD;
                    else
                        state_nxt = S_WR;
                end
            end
            S_RD:    state_nxt = write_q ? S_WR : S_RESP;
            S_WR:    state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            old_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                size_q   <= req_size;
                signed_q <= req_signed;
                write_q  <= req_write;
                err_q    <= access_bad;
            end
            if (state == S_RD)
                old_q <= mem_dataOut;
        end
    end

    // Reserved size falls through to the word paths in both merge and extraction.
    always_comb begin
        merged_wdata = wdata_q;
        case (size_q)
            SZ_BYTE: merged_wdata = {old_q[31:8],  wdata_q[7:0]};
            SZ_HALF: merged_wdata = {old_q[31:16], wdata_q[15:0]};
            default: merged_wdata = wdata_q;
        endcase
    end

    always_comb begin
        load_data = old_q;
        case (size_q)
            SZ_BYTE: load_data = {{24{signed_q & old_q[7]}},  old_q[7:0]};
            SZ_HALF: load_data = {{16{signed_q & old_q[15]}}, old_q[15:0]};
            default: load_data = old_q;
        endcase
    end

    assign req_ready = (state == S_IDLE) && rst_n;
    assign rsp_valid = (state == S_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !write_q && !err_q) ? load_data : 32'd0;

    // The strobe is gated by rst_n as well, so an asserted reset removes it without waiting for an edge.
    assign mem_write   = (state == S_WR) && rst_n;
    assign mem_address = ((state == S_RD) || (state == S_WR)) ? addr_q : 32'd0;
    assign mem_dataIn  = (state == S_WR) ? merged_wdata : 32'd0;
    assign mem_word    = 1'b1;
    assign mem_sign    = 1'b0;

endmodule
